// File: rtl/dss_bpsk_spreader.sv
// dss_bpsk_spreader
//   Direct-sequence spread-spectrum BPSK stage placed after the carrier NCO.
//   Each data bit is spread by a 5-stage m-sequence (x^5+x^2+1, period 31).
//   Each carrier sample is passed through or negated, depending on the
//   current chip (data XOR pn).
//
// Optional feature (macro DSS_PN_LOAD_EN):
//   Adds pn_load/pn_seed. These reseed the LFSR and restart the bit framing.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   clken           clock enable; all state advances only when high
//   carrier_i       signed NCO sine sample (mpr bits)
//   carrier_valid   carrier_i qualifier
//   data_i          data bit, held by upstream until data_req
//   data_req        one-clock pulse after data_i has been captured
//   mod_o           signed spread-BPSK sample (mpr bits), 1 clk latency
//   mod_valid       mod_o qualifier
//   chip_o          chip applied to mod_o
//   pn_sync         marks the first output sample of each bit period
//   pn_load, pn_seed  (DSS_PN_LOAD_EN only) LFSR reseed request and value
module dss_bpsk_spreader #(
  parameter int          mpr     = 10,
  parameter int          spc     = 8,
  parameter int          cpb     = 31,
  parameter logic [4:0]  pn_init = 5'b11111
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic signed [mpr-1:0] carrier_i,
  input  logic                  carrier_valid,
  input  logic                  data_i,
`ifdef DSS_PN_LOAD_EN
  input  logic                  pn_load,
  input  logic [4:0]            pn_seed,
`endif
  output logic                  data_req,
  output logic signed [mpr-1:0] mod_o,
  output logic                  mod_valid,
  output logic                  chip_o,
  output logic                  pn_sync
);

  localparam int SCW = (spc > 1) ? $clog2(spc) : 1;
  localparam int CCW = (cpb > 1) ? $clog2(cpb) : 1;
  localparam logic signed [mpr-1:0] S_MIN = {1'b1, {(mpr-1){1'b0}}};
  localparam logic signed [mpr-1:0] S_MAX = {1'b0, {(mpr-1){1'b1}}};

  // Negation with the single overflow case (most negative code) clipped.
  function automatic logic signed [mpr-1:0] neg_sat(input logic signed [mpr-1:0] x);
    if (x == S_MIN) return S_MAX;
    else            return -x;
  endfunction

  logic [SCW-1:0]        r_sample_cnt;
  logic [CCW-1:0]        r_chip_cnt;
  logic [4:0]            r_lfsr;
  logic                  r_bit;
  logic signed [mpr-1:0] r_mod_p1;
  logic                  r_vld_p1;
  logic                  r_chip_p1;
  logic                  r_sync_p1;
  logic                  r_req_p1;

  logic                  w_adv;
  logic                  w_load;
  logic [4:0]            w_seed;
  logic                  w_cap;
  logic                  w_bit_eff;
  logic                  w_chip;
  logic                  w_sample_wrap;
  logic                  w_chip_wrap;
  logic [4:0]            w_lfsr_next;

  assign w_adv = clken & carrier_valid;

`ifdef DSS_PN_LOAD_EN
  assign w_load = pn_load & clken;
  // A zero seed would lock the LFSR, so fall back to pn_init.
  assign w_seed = (pn_seed == 5'd0) ? pn_init : pn_seed;
`else
  assign w_load = 1'b0;
  assign w_seed = pn_init;
`endif

  // Start of a bit period: data_i is consumed live on this sample.
  assign w_cap         = (r_sample_cnt == '0) && (r_chip_cnt == '0);
  assign w_bit_eff     = w_cap ? data_i : r_bit;
  assign w_chip        = w_bit_eff ^ r_lfsr[4];
  assign w_sample_wrap = (r_sample_cnt == SCW'(spc - 1));
  assign w_chip_wrap   = (r_chip_cnt == CCW'(cpb - 1));
  // Fibonacci step. A zero state is forced back to the seed.
  assign w_lfsr_next   = (r_lfsr == 5'd0) ? pn_init
                                          : {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[1]};

  // ---- stage p0 -> p1: counters, LFSR, bit capture, output register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample_cnt <= '0;
      r_chip_cnt   <= '0;
      r_lfsr       <= pn_init;
      r_bit        <= 1'b0;
      r_mod_p1     <= '0;
      r_vld_p1     <= 1'b0;
      r_chip_p1    <= 1'b0;
      r_sync_p1    <= 1'b0;
      r_req_p1     <= 1'b0;
    end else begin
      r_vld_p1 <= w_adv & ~w_load;
      r_req_p1 <= w_adv & ~w_load & w_cap;
      if (w_load) begin
        r_lfsr       <= w_seed;
        r_sample_cnt <= '0;
        r_chip_cnt   <= '0;
      end else if (w_adv) begin
        r_mod_p1  <= w_chip ? neg_sat(carrier_i) : carrier_i;
        r_chip_p1 <= w_chip;
        r_sync_p1 <= w_cap;
        if (w_cap) r_bit <= data_i;
        if (w_sample_wrap) begin
          r_sample_cnt <= '0;
          r_lfsr       <= w_lfsr_next;
          r_chip_cnt   <= w_chip_wrap ? '0 : r_chip_cnt + CCW'(1);
        end else begin
          r_sample_cnt <= r_sample_cnt + SCW'(1);
        end
      end
    end
  end

  assign mod_o     = r_mod_p1;
  assign mod_valid = r_vld_p1;
  assign chip_o    = r_chip_p1;
  assign pn_sync   = r_sync_p1;
  assign data_req  = r_req_p1;

endmodule

// File: tb/tb_dss_bpsk_spreader.sv
// Bench for dss_bpsk_spreader. A reference model predicts every output.
// The model works from the adv count since reset/reseed and from the
// m-sequence generated by its linear recurrence.
module tb_dss_bpsk_spreader;
  localparam int MPR = 10;
  localparam int SPC = 8;
  localparam int CPB = 31;
  localparam logic [4:0] PN_INIT = 5'b11111;

  logic clk = 1'b0;
  logic reset, clken, carrier_valid, data_i;
  logic signed [MPR-1:0] carrier_i;
  logic data_req, mod_valid, chip_o, pn_sync;
  logic signed [MPR-1:0] mod_o;
`ifdef DSS_PN_LOAD_EN
  logic pn_load;
  logic [4:0] pn_seed;
`endif

  dss_bpsk_spreader #(.mpr(MPR), .spc(SPC), .cpb(CPB), .pn_init(PN_INIT)) dut (
    .clk(clk), .reset(reset), .clken(clken), .carrier_i(carrier_i),
    .carrier_valid(carrier_valid), .data_i(data_i),
`ifdef DSS_PN_LOAD_EN
    .pn_load(pn_load), .pn_seed(pn_seed),
`endif
    .data_req(data_req), .mod_o(mod_o), .mod_valid(mod_valid),
    .chip_o(chip_o), .pn_sync(pn_sync));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_n;        // qualifying samples since reset/reseed
  bit m_bit;
  bit seq[31];    // one period of the m-sequence from the current seed
  int e_mod;
  bit e_vld, e_chip, e_sync, e_req;

  function automatic void build_seq(input logic [4:0] s);
    for (int k = 0; k < 5; k++) seq[k] = s[4-k];
    for (int k = 0; k < 26; k++) seq[k+5] = seq[k] ^ seq[k+3];
  endfunction

  function automatic void model_reset();
    m_n = 0; m_bit = 0; build_seq(PN_INIT);
    e_mod = 0; e_vld = 0; e_chip = 0; e_sync = 0; e_req = 0;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".vld"},  int'(mod_valid), int'(e_vld));
    chk({tag, ".mod"},  int'(mod_o),     e_mod);
    chk({tag, ".chip"}, int'(chip_o),    int'(e_chip));
    chk({tag, ".sync"}, int'(pn_sync),   int'(e_sync));
    chk({tag, ".req"},  int'(data_req),  int'(e_req));
  endtask

  // One clock: apply inputs, advance the model, check 1 time unit after the edge.
  task automatic step(input string tag, input bit ce, input bit cv, input bit d,
                      input int car, input bit ld, input logic [4:0] sd);
    bit adv, cap, chip;
    int neg;
    clken = ce; carrier_valid = cv; data_i = d; carrier_i = MPR'(car);
`ifdef DSS_PN_LOAD_EN
    pn_load = ld; pn_seed = sd;
`endif
    @(posedge clk);
    adv = ce & cv;
    e_req = 0;
`ifdef DSS_PN_LOAD_EN
    if (ld && ce) begin
      e_vld = 0; m_n = 0;
      build_seq(sd == 5'd0 ? PN_INIT : sd);
    end else
`endif
    begin
      e_vld = adv;
      if (adv) begin
        cap = (m_n % (SPC * CPB)) == 0;
        if (cap) m_bit = d;
        chip = m_bit ^ seq[(m_n / SPC) % 31];
        neg = -car;
        if (neg > 511) neg = 511;
        e_mod = chip ? neg : car;
        e_chip = chip; e_sync = cap; e_req = cap;
        m_n++;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    // reset is asynchronous: outputs must already be cleared
    chk("async_rst.mod", int'(mod_o), 0);
    chk("async_rst.vld", int'(mod_valid), 0);
    chk("async_rst.chip", int'(chip_o), 0);
    chk("async_rst.sync", int'(pn_sync), 0);
    chk("async_rst.req", int'(data_req), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clken = 0; carrier_valid = 0; data_i = 0; carrier_i = '0;
`ifdef DSS_PN_LOAD_EN
    pn_load = 0; pn_seed = '0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;

    // data 0, carrier +100: five 1-chips (-100 for 40 samples), then +100
    for (int i = 0; i < 48; i++) begin
      step("d0", 1, 1, 0, 100, 0, 5'd0);
      if (i == 0)  chk("d0.first", int'(mod_o), -100);
      if (i == 39) chk("d0.s40", int'(mod_o), -100);
      if (i == 40) chk("d0.s41", int'(mod_o), 100);
    end

    // data 1: inverted pattern, data_req every 248 samples
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step("d1", 1, 1, 1, 100, 0, 5'd0);
      if (i == 0)   chk("d1.first", int'(mod_o), 100);
      if (i == 0)   chk("d1.req1", int'(data_req), 1);
      if (i == 40)  chk("d1.s41", int'(mod_o), -100);
      if (i == 248) chk("d1.req249", int'(data_req), 1);
    end

    // saturation on negation
    do_reset();
    step("sat", 1, 1, 0, -512, 0, 5'd0);
    chk("sat.neg512", int'(mod_o), 511);
    step("sat", 1, 1, 0, 511, 0, 5'd0);
    chk("sat.pos511", int'(mod_o), -511);

    // carrier_valid toggling every clock
    do_reset();
    for (int i = 0; i < 600; i++)
      step("toggle", 1, i % 2 == 0, 1, 200, 0, 5'd0);

    // reset in the middle of chip 17, then the sequence restarts
    do_reset();
    for (int i = 0; i < 16 * SPC + 3; i++) step("pre", 1, 1, 0, 37, 0, 5'd0);
    do_reset();
    for (int i = 0; i < 48; i++) begin
      step("post", 1, 1, 0, 100, 0, 5'd0);
      if (i == 0)  chk("post.req", int'(data_req), 1);
      if (i == 0)  chk("post.first", int'(mod_o), -100);
      if (i == 40) chk("post.s41", int'(mod_o), 100);
    end

`ifdef DSS_PN_LOAD_EN
    step("load1", 1, 1, 0, 100, 1, 5'b00001);
    for (int i = 0; i < 40; i++) begin
      step("seed1", 1, 1, 0, 100, 0, 5'd0);
      if (i == 0)  chk("seed1.first", int'(mod_o), 100);
      if (i == 32) chk("seed1.s33", int'(mod_o), -100);
    end
    step("load0", 1, 1, 0, 100, 1, 5'b00000);
    for (int i = 0; i < 48; i++) begin
      step("seed0", 1, 1, 0, 100, 0, 5'd0);
      if (i == 0)  chk("seed0.first", int'(mod_o), -100);
      if (i == 40) chk("seed0.s41", int'(mod_o), 100);
    end
`endif

    // randomized enables, carrier and data
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int car;
      car = int'($urandom_range(0, 1023)) - 512;
      step("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), car,
           $urandom_range(0, 299) == 0, 5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
